// File: rtl/branch_hazard_ctrl.sv
// Fetch-side control-hazard sequencer: freezes the PC and bubbles IF/ID while a
// branch is in flight, then issues a single-cycle redirect when EX resolves it taken.
module branch_hazard_ctrl #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int RESOLVE_TIMEOUT   = 7,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         If_Valid,
    input  logic                         Br_Detected,
    input  logic                         Ex_Stall,
    input  logic                         Ex_Br_Resolved,
    input  logic                         Ex_Br_Taken,
    input  logic [WIDTH_DATA_LENGTH-1:0] Ex_Br_Target,
    output logic                         Pc_Stall,
    output logic                         If_Id_Flush,
    output logic                         Pc_Sel,
    output logic [WIDTH_DATA_LENGTH-1:0] Pc_Target,
    output logic                         Busy,
    output logic [CNT_WIDTH-1:0]         Br_Count,
    output logic [CNT_WIDTH-1:0]         Taken_Count,
    output logic                         Timeout_Err
);

    localparam int WAIT_W = (RESOLVE_TIMEOUT > 1) ? $clog2(RESOLVE_TIMEOUT) : 1;

    // Control output bundle order: {Pc_Stall, If_Id_Flush, Pc_Sel, Busy}
    localparam logic [3:0] CTL_IDLE  = 4'b0000;
    localparam logic [3:0] CTL_HOLD  = 4'b1101;
    localparam logic [3:0] CTL_REDIR = 4'b0111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t                         state_q;
    logic [WAIT_W-1:0]              wait_cnt_q;
    logic [3:0]                     ctl_q;
    logic [WIDTH_DATA_LENGTH-1:0]   target_q;
    logic [CNT_WIDTH-1:0]           br_cnt_q;
    logic [CNT_WIDTH-1:0]           taken_cnt_q;
    logic                           timeout_err_q;

    // Control outputs are loaded alongside the state so they always match it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            ctl_q         <= CTL_IDLE;
            target_q      <= '0;
            br_cnt_q      <= '0;
            taken_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (If_Valid && Br_Detected) begin
                        state_q    <= HOLD;
                        ctl_q      <= CTL_HOLD;
                        wait_cnt_q <= '0;
                        if (br_cnt_q != '1)
                            br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    // A frozen EX may show stale resolve signals, so nothing advances.
                    if (!Ex_Stall) begin
                        if (Ex_Br_Resolved) begin
                            if (Ex_Br_Taken) begin
                                state_q  <= REDIRECT;
                                ctl_q    <= CTL_REDIR;
                                target_q <= Ex_Br_Target;
                                if (taken_cnt_q != '1)
                                    taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
                            end else begin
                                state_q <= IDLE;
                                ctl_q   <= CTL_IDLE;
                            end
                        end else if (wait_cnt_q == WAIT_W'(RESOLVE_TIMEOUT - 1)) begin
                            state_q       <= IDLE;
                            ctl_q         <= CTL_IDLE;
                            timeout_err_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                        end
                    end
                end
                REDIRECT: begin
                    state_q <= IDLE;
                    ctl_q   <= CTL_IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ctl_q   <= CTL_IDLE;
                end
            endcase
        end
    end

    assign {Pc_Stall, If_Id_Flush, Pc_Sel, Busy} = ctl_q;
    assign Pc_Target   = target_q;
    assign Br_Count    = br_cnt_q;
    assign Taken_Count = taken_cnt_q;
    assign Timeout_Err = timeout_err_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: a vector table of per-edge stimulus and
// expected outputs, plus hand sequences for counter saturation and async reset.
module tb_branch_hazard_ctrl;

    localparam int W  = 32;
    localparam int CW = 4;

    localparam logic [3:0] C_IDLE  = 4'b0000;
    localparam logic [3:0] C_HOLD  = 4'b1101;
    localparam logic [3:0] C_REDIR = 4'b0111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifValid, brDet, exStall, exRes, exTaken;
    logic [W-1:0]  exTarget;
    logic          pcStall, ifIdFlush, pcSel, busy, timeoutErr;
    logic [W-1:0]  pcTarget;
    logic [CW-1:0] brCount, takenCount;

    int checks = 0;
    int fails  = 0;

    branch_hazard_ctrl #(
        .WIDTH_DATA_LENGTH(W),
        .RESOLVE_TIMEOUT  (7),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .If_Valid      (ifValid),
        .Br_Detected   (brDet),
        .Ex_Stall      (exStall),
        .Ex_Br_Resolved(exRes),
        .Ex_Br_Taken   (exTaken),
        .Ex_Br_Target  (exTarget),
        .Pc_Stall      (pcStall),
        .If_Id_Flush   (ifIdFlush),
        .Pc_Sel        (pcSel),
        .Pc_Target     (pcTarget),
        .Busy          (busy),
        .Br_Count      (brCount),
        .Taken_Count   (takenCount),
        .Timeout_Err   (timeoutErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v, d, s, r, t;
        logic [W-1:0]  tgt;
        logic [3:0]    eCtl;
        logic          eErr;
        logic [W-1:0]  eTgt;
        logic [CW-1:0] eBr, eTk;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic v, d, s, r, t, input logic [W-1:0] tgt,
                          input logic [3:0] eCtl, input logic eErr,
                          input logic [W-1:0] eTgt, input logic [CW-1:0] eBr, eTk);
        vec_t x;
        x.v = v; x.d = d; x.s = s; x.r = r; x.t = t; x.tgt = tgt;
        x.eCtl = eCtl; x.eErr = eErr; x.eTgt = eTgt; x.eBr = eBr; x.eTk = eTk;
        vecs.push_back(x);
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] eCtl, input logic eErr,
                            input logic [W-1:0] eTgt, input logic [CW-1:0] eBr, eTk);
        checkOutput({tag, " ctl"}, W'({pcStall, ifIdFlush, pcSel, busy}), W'(eCtl));
        checkOutput({tag, " err"}, W'(timeoutErr), W'(eErr));
        checkOutput({tag, " target"}, pcTarget, eTgt);
        checkOutput({tag, " brCount"}, W'(brCount), W'(eBr));
        checkOutput({tag, " takenCount"}, W'(takenCount), W'(eTk));
    endtask

    // Drive on the falling edge, let one rising edge happen, sample 1 time unit later.
    task automatic applyStimulus(input logic v, d, s, r, t, input logic [W-1:0] tgt);
        @(negedge clk);
        ifValid = v; brDet = d; exStall = s; exRes = r; exTaken = t; exTarget = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CW-1:0] brExp, tkExp;
        logic [W-1:0]  tgtExp;

        rst_n = 1'b0;
        ifValid = 0; brDet = 0; exStall = 0; exRes = 0; exTaken = 0; exTarget = '0;

        // Not-taken branch: two bubble cycles, no redirect
        addVec(1,1,0,0,0,32'h0,     C_HOLD,  0, 32'h0,   1, 0);
        addVec(0,0,0,0,0,32'h0,     C_HOLD,  0, 32'h0,   1, 0);
        addVec(0,0,0,1,0,32'h55,    C_IDLE,  0, 32'h0,   1, 0);
        addVec(0,0,0,0,0,32'h0,     C_IDLE,  0, 32'h0,   1, 0);
        // Taken branch to 0x100
        addVec(1,1,0,0,0,32'h0,     C_HOLD,  0, 32'h0,   2, 0);
        addVec(0,0,0,0,0,32'h0,     C_HOLD,  0, 32'h0,   2, 0);
        addVec(0,0,0,1,1,32'h100,   C_REDIR, 0, 32'h100, 2, 1);
        addVec(0,0,0,0,0,32'h0,     C_IDLE,  0, 32'h100, 2, 1);
        // EX stall for 10 cycles with a stale resolve pulse, then not-taken
        addVec(1,1,0,0,0,32'h0,     C_HOLD,  0, 32'h100, 3, 1);
        for (int i = 0; i < 10; i++)
            addVec(0,0,1,(i==2||i==3),1,32'hDEAD, C_HOLD, 0, 32'h100, 3, 1);
        addVec(0,0,0,1,0,32'h0,     C_IDLE,  0, 32'h100, 3, 1);
        // Timeout: seven HOLD cycles then IDLE with the sticky error
        addVec(1,1,0,0,0,32'h0,     C_HOLD,  0, 32'h100, 4, 1);
        for (int i = 0; i < 6; i++)
            addVec(0,0,0,0,0,32'h0, C_HOLD,  0, 32'h100, 4, 1);
        addVec(0,0,0,0,0,32'h0,     C_IDLE,  1, 32'h100, 4, 1);
        addVec(1,1,0,0,0,32'h0,     C_HOLD,  1, 32'h100, 5, 1);
        addVec(0,0,0,1,0,32'h0,     C_IDLE,  1, 32'h100, 5, 1);
        // Back-to-back detect held high through HOLD and REDIRECT
        addVec(1,1,0,0,0,32'h0,     C_HOLD,  1, 32'h100, 6, 1);
        addVec(1,1,0,1,1,32'h200,   C_REDIR, 1, 32'h200, 6, 2);
        addVec(1,1,0,0,0,32'h0,     C_IDLE,  1, 32'h200, 6, 2);
        addVec(1,1,0,0,0,32'h0,     C_HOLD,  1, 32'h200, 7, 2);
        addVec(1,1,0,1,0,32'h0,     C_IDLE,  1, 32'h200, 7, 2);
        // Detect without If_Valid and resolve while IDLE are both ignored
        addVec(0,1,0,1,1,32'h300,   C_IDLE,  1, 32'h200, 7, 2);

        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", C_IDLE, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].r, vecs[i].t, vecs[i].tgt);
            checkAll($sformatf("vec%0d", i), vecs[i].eCtl, vecs[i].eErr, vecs[i].eTgt,
                     vecs[i].eBr, vecs[i].eTk);
        end

        // Saturation: keep taking branches past the counter maximum
        brExp = 7; tkExp = 2;
        for (int i = 0; i < 14; i++) begin
            tgtExp = 32'h1000 + 32'(i * 4);
            applyStimulus(1,1,0,0,0,32'h0);
            if (brExp != '1) brExp = brExp + 1'b1;
            checkAll($sformatf("sat%0d hold", i), C_HOLD, 1, pcTarget, brExp, tkExp);
            applyStimulus(0,0,0,1,1,tgtExp);
            if (tkExp != '1) tkExp = tkExp + 1'b1;
            checkAll($sformatf("sat%0d redir", i), C_REDIR, 1, tgtExp, brExp, tkExp);
            applyStimulus(0,0,0,0,0,32'h0);
        end
        checkOutput("brCount saturated", W'(brCount), W'(4'hF));
        checkOutput("takenCount saturated", W'(takenCount), W'(4'hF));

        // Async reset between edges while in HOLD
        applyStimulus(1,1,0,0,0,32'h0);
        checkOutput("pre-reset stall", W'(pcStall), W'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("async reset", C_IDLE, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ifValid = 0; brDet = 0;
        applyStimulus(1,1,0,0,0,32'h0);
        checkAll("post-reset detect", C_HOLD, 0, 32'h0, 1, 0);
        applyStimulus(0,0,0,1,1,32'h40);
        checkAll("post-reset redir", C_REDIR, 0, 32'h40, 1, 1);
        applyStimulus(0,0,0,0,0,32'h0);
        checkAll("post-reset idle", C_IDLE, 0, 32'h40, 1, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
